sd_cmd_sequencer: RTL and testbench
===================================

# sd_cmd_sequencer

Parametrised next-generation SD command-path master. Sits between the wishbone SD host register file and the serial command engine. Builds the 40-bit command token and serial settings word, runs a synchronised four-phase req/ack handshake, and enforces a watchdog timeout. Captures short (R1/R3/R6) and long (R2, 128-bit) responses, and can optionally re-issue failed commands on its own.

## Interface
- ARG_W, 32: command argument width; must be 32 for SD, other values only for bench reuse.
- TIMEOUT_W, 16: watchdog/timeout width.
- SYNC_STAGES, 2: synchroniser depth on req_in/ack_in; 2..4.
- DEBOUNCE_W, 4: card-detect debounce counter width.
- MAX_RETRY, 3: automatic re-issues per command; 0..7.

Ports:
- clk  in  1  system clock; the only clock; everything is clocked here.
- rst  in  1  reset; synchronous, active-high.
- new_cmd  in  1  one-cycle start pulse; ignored unless busy=0.
- cmd_index  in  6  command index.
- arg  in  ARG_W  command argument.
- rsp_type  in  2  response type: 00 none, 01 long (136-bit), 10 short, 11 short with busy.
- crc_chk_en, idx_chk_en  in  1 each  enable response CRC check and response index check.
- data_read, data_write  in  1 each  data phase type; copied into settings.
- word_sel  in  2  copied into settings[14:13].
- timeout  in  TIMEOUT_W  watchdog limit in clk cycles.
- int_clr  in  1  clears err_int and done_int.
- busy  out  1  high whenever state is not IDLE.
- resp  out  128  captured response.
- done_int  out  1  sticky command-complete flag.
- err_int  out  5  sticky flags: [0] timeout, [1] CRC, [2] retry exhausted, [3] index, [4] error summary (OR of [3:0]).
- retry_cnt  out  3  re-issues used for the current command.
- card_present  out  1  debounced card detect.
- go_idle_o  out  1  one-cycle abort pulse to the serial engine.
- cmd_out  out  40  {2'b01, cmd_index, arg}.
- settings  out  16  {1'b0, word_sel, data_read, data_write, 3'b111, crc_chk_en, rsp_len[6:0]}.
  - rsp_len: 0 for none; 7'd40 for short; 7'd127 for long.
- req_out  out  1  command request to the serial engine.
- ack_out  out  1  status acknowledge to the serial engine.
- req_in, ack_in  in  1 each  asynchronous handshake lines from the serial engine.
- cmd_in  in  128  received response.
  - Short response: cmd_in[37:32] is the index and cmd_in[31:0] is the payload.
- serial_status  in  8  [6] response available, [5] CRC valid.
- card_detect_n  in  1  active-low card-detect switch.

## Operation
- States: IDLE, SETUP, EXECUTE, RETRY. Any undefined state returns to IDLE.
- IDLE:
  - On new_cmd: latch all command inputs, clear err_int, done_int and retry_cnt, then go to SETUP.
  - If a synchronised req_in arrives while in IDLE, acknowledge it and drop it.
- SETUP:
  - Drive cmd_out and settings, clear the watchdog, assert req_out.
  - Stay until synchronised ack_in=1, then drop req_out and go to EXECUTE.
- EXECUTE:
  - Watchdog increments every cycle; it saturates and does not wrap.
  - On synchronised req_in=1 with ack_out=0: capture serial_status and assert ack_out. Hold ack_out until synchronised req_in=0.
  - If captured status[6]=1, evaluate the response:
    - CRC error: crc_chk_en=1 and status[5]=0.
    - Index error: idx_chk_en=1 and cmd_in[37:32] differs from cmd_index.
    - Load resp unless rsp_type=00. Short responses zero-extend cmd_in[31:0]; long responses load the full 128 bits.
    - If the command is not retried (see below), set done_int and any error flags, then go to IDLE.
  - Timeout: watchdog == timeout. Pulse go_idle_o, set err_int[0] (unless retried), go to IDLE.
  - If response-available and timeout happen in the same cycle, the response wins.
- RETRY (macro builds only):
  - Entered on CRC error or timeout when retry_cnt < MAX_RETRY. Index errors are never retried.
  - Wait until synchronised req_in=0 and ack_in=0, increment retry_cnt, go to SETUP.
  - If the limit is reached, also set err_int[2].
- err_int[4] is always the OR of err_int[3:0].
- int_clr has priority over a flag set in the same cycle.
- card_present:
  - Debounce counter counts up while card_detect_n=0 and saturates at all-ones; it resets to 0 when card_detect_n=1.
  - card_present=1 only while the counter is saturated.

## Timing
- Reset: every output is 0 and state is IDLE. Reset mid-command aborts without a go_idle_o pulse.
- new_cmd to req_out: 2 cycles (IDLE→SETUP, then registered req_out).
- Handshake input latency: SYNC_STAGES cycles from a req_in/ack_in edge to the internal copy.
- All outputs are registered; no combinational path from any input to any output.
- go_idle_o and the done_int rising edge occur on the same cycle as the return to IDLE.

## Configuration
- SD_CMD_AUTO_RETRY_EN defined: RETRY state and retry_cnt are active, as described above.
- Not defined:
  - RETRY state is not built and retry_cnt reads 0.
  - The first CRC error or timeout sets its flag immediately; err_int[2] is never set.

## Test plan
- Short response:
  - Stimulus: new_cmd with index 17, arg 0x0000_0200, rsp_type 10; engine returns status 0x60 and cmd_in[37:0] = {6'd17, 32'h0000_0900}.
  - Required: resp=0x900, done_int=1, err_int=0, cmd_out=0x51_0000_0200, settings[6:0]=40.
- Long response:
  - Stimulus: rsp_type 01; cmd_in = 128'hA5 pattern.
  - Required: resp equals the full 128-bit pattern, settings[6:0]=127.
- Timeout:
  - Stimulus: timeout=20, serial engine never answers.
  - Required: go_idle_o pulses once; err_int=5'b10001 (retry build: after MAX_RETRY+1 attempts, err_int=5'b10101, retry_cnt=3).
- CRC error:
  - Stimulus: crc_chk_en=1, status 0x40 on the first attempt, 0x60 on the second (retry build).
  - Required: retry_cnt=1, err_int=0, done_int=1. Non-retry build: err_int=5'b10010.
- Index mismatch plus card detect:
  - Stimulus: idx_chk_en=1 with returned index 3 ≠ 17; separately hold card_detect_n=0.
  - Required: err_int=5'b11000 with no retry; card_present rises 16 cycles after card_detect_n falls (DEBOUNCE_W=4).
- Reset and clear:
  - Stimulus: rst asserted in EXECUTE; separately int_clr coincident with a CRC flag set.
  - Required: after rst, all outputs 0 and state IDLE; the coincident int_clr leaves err_int=0.

Source files
------------

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer
//   SD command-path master between the host register file and the serial
//   command engine. Latches a command, presents the 40-bit token and the
//   16-bit settings word, runs the request/acknowledge handshakes, guards the
//   response phase with a watchdog and captures short/long responses.
//
//   Optional feature macro: SD_CMD_AUTO_RETRY_EN
//     defined   : CRC errors and timeouts are re-issued up to MAX_RETRY times
//     undefined : no RETRY state, retry_cnt stays 0, first failure is flagged
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   new_cmd           start pulse, accepted only while idle
//   cmd_index, arg    command index and argument
//   rsp_type          00 none, 01 long, 10 short, 11 short with busy
//   crc_chk_en        enable response CRC check
//   idx_chk_en        enable response index check
//   data_read/write   data phase type, copied into settings
//   word_sel          copied into settings[14:13]
//   timeout           watchdog limit in clk cycles
//   int_clr           clears err_int and done_int (wins over a same-cycle set)
//   busy              state is not IDLE
//   resp              captured response
//   done_int          sticky completion flag
//   err_int           [0] timeout [1] CRC [2] retry exhausted [3] index [4] OR
//   retry_cnt         re-issues used by the current command
//   card_present      debounced card detect
//   go_idle_o         one-cycle abort pulse to the serial engine
//   cmd_out           {2'b01, cmd_index, arg}
//   settings          {0, word_sel, data_read, data_write, 111, crc_chk_en, rsp_len}
//   req_out, ack_in   command request to the engine / engine acknowledge
//   req_in, ack_out   status request from the engine / our acknowledge
//   cmd_in            received response bits
//   serial_status     [6] response available, [5] CRC valid
//   card_detect_n     active-low card-detect switch
//   state_dbg         current FSM state
//   status_dbg        serial_status captured at the last status handshake
//
// Handshakes: both directions are four-phase. The requester raises req and
// holds it until it sees ack high, then drops req; the acknowledger holds ack
// high until it sees req low, then drops ack. req_in/ack_in are asynchronous
// and pass through SYNC_STAGES flops before use.

module sd_cmd_sequencer #(
  parameter int ARG_W       = 32,
  parameter int TIMEOUT_W   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 4,
  parameter int MAX_RETRY   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 new_cmd,
  input  logic [5:0]           cmd_index,
  input  logic [ARG_W-1:0]     arg,
  input  logic [1:0]           rsp_type,
  input  logic                 crc_chk_en,
  input  logic                 idx_chk_en,
  input  logic                 data_read,
  input  logic                 data_write,
  input  logic [1:0]           word_sel,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 int_clr,
  output logic                 busy,
  output logic [127:0]         resp,
  output logic                 done_int,
  output logic [4:0]           err_int,
  output logic [2:0]           retry_cnt,
  output logic                 card_present,
  output logic                 go_idle_o,
  output logic [ARG_W+7:0]     cmd_out,
  output logic [15:0]          settings,
  output logic                 req_out,
  output logic                 ack_out,
  input  logic                 req_in,
  input  logic                 ack_in,
  input  logic [127:0]         cmd_in,
  input  logic [7:0]           serial_status,
  input  logic                 card_detect_n,
  output logic [1:0]           state_dbg,
  output logic [7:0]           status_dbg
);

`ifdef SD_CMD_AUTO_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam logic [2:0] MAX_RETRY_L = 3'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    EXECUTE = 2'd2,
    RETRY   = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] req_sync, ack_sync;
  logic                   req_s, ack_s;
  logic [TIMEOUT_W-1:0]   wd, timeout_q;
  logic [5:0]             idx_q;
  logic [1:0]             rsp_type_q;
  logic                   crc_en_q, idx_en_q;
  logic [DEBOUNCE_W-1:0]  deb_cnt;

  logic       capture, rsp_evt, to_evt, crc_err, idx_err, can_retry, retry_go;
  logic [3:0] err_set, err_nxt;
  logic       done_set, done_nxt;

  assign req_s     = req_sync[SYNC_STAGES-1];
  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign state_dbg = state;

  function automatic logic [6:0] rsp_len(input logic [1:0] t);
    case (t)
      2'b00:   return 7'd0;
      2'b01:   return 7'd127;
      default: return 7'd40;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req_in};
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
    end
  end

  // Response evaluation and flag bookkeeping. A response seen in the same
  // cycle as the watchdog limit takes precedence over the timeout.
  always_comb begin
    capture   = (state == EXECUTE) && req_s && !ack_out;
    rsp_evt   = capture && serial_status[6];
    to_evt    = (state == EXECUTE) && !rsp_evt && (wd == timeout_q);
    crc_err   = crc_en_q && !serial_status[5];
    idx_err   = idx_en_q && (cmd_in[37:32] != idx_q);
    can_retry = RETRY_EN && (retry_cnt < MAX_RETRY_L);
    // Index errors are never re-issued.
    retry_go  = can_retry && ((rsp_evt && crc_err && !idx_err) || to_evt);
    err_set   = 4'b0000;
    done_set  = 1'b0;
    if (rsp_evt && !retry_go) begin
      done_set   = 1'b1;
      err_set[1] = crc_err;
      err_set[3] = idx_err;
      err_set[2] = RETRY_EN && crc_err && !idx_err;
    end
    if (to_evt && !retry_go) begin
      err_set[0] = 1'b1;
      err_set[2] = RETRY_EN;
    end
    if (int_clr || (state == IDLE && new_cmd)) begin
      err_nxt  = 4'b0000;
      done_nxt = 1'b0;
    end else begin
      err_nxt  = err_int[3:0] | err_set;
      done_nxt = done_int | done_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      resp       <= '0;
      done_int   <= 1'b0;
      err_int    <= '0;
      retry_cnt  <= '0;
      go_idle_o  <= 1'b0;
      cmd_out    <= '0;
      settings   <= '0;
      req_out    <= 1'b0;
      ack_out    <= 1'b0;
      status_dbg <= '0;
      wd         <= '0;
      timeout_q  <= '0;
      idx_q      <= '0;
      rsp_type_q <= '0;
      crc_en_q   <= 1'b0;
      idx_en_q   <= 1'b0;
    end else begin
      go_idle_o <= 1'b0;
      // Any synchronised request is acknowledged; only EXECUTE acts on it.
      ack_out   <= req_s;
      err_int   <= {|err_nxt, err_nxt};
      done_int  <= done_nxt;
      if (capture) status_dbg <= serial_status;
      if (rsp_evt) begin
        case (rsp_type_q)
          2'b01:        resp <= cmd_in;
          2'b10, 2'b11: resp <= {96'd0, cmd_in[31:0]};
          default:      ;
        endcase
      end
      case (state)
        IDLE: begin
          if (new_cmd) begin
            idx_q      <= cmd_index;
            rsp_type_q <= rsp_type;
            crc_en_q   <= crc_chk_en;
            idx_en_q   <= idx_chk_en;
            timeout_q  <= timeout;
            cmd_out    <= {2'b01, cmd_index, arg};
            settings   <= {1'b0, word_sel, data_read, data_write, 3'b111,
                           crc_chk_en, rsp_len(rsp_type)};
            retry_cnt  <= '0;
            busy       <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          wd <= '0;
          if (ack_s) begin
            req_out <= 1'b0;
            state   <= EXECUTE;
          end else begin
            req_out <= 1'b1;
          end
        end
        EXECUTE: begin
          if (wd != '1) wd <= wd + 1'b1;
          if (to_evt) go_idle_o <= 1'b1;
          if (retry_go) begin
            state <= RETRY;
          end else if (rsp_evt || to_evt) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
`ifdef SD_CMD_AUTO_RETRY_EN
        RETRY: begin
          // Let both handshakes settle before re-issuing.
          if (!req_s && !ack_s) begin
            retry_cnt <= retry_cnt + 1'b1;
            state     <= SETUP;
          end
        end
`endif
        default: begin
          busy    <= 1'b0;
          req_out <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Card detect: present only after DEBOUNCE_W-bit counter saturates low.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt      <= '0;
      card_present <= 1'b0;
    end else begin
      if (card_detect_n) deb_cnt <= '0;
      else if (deb_cnt != '1) deb_cnt <= deb_cnt + 1'b1;
      card_present <= !card_detect_n && (deb_cnt == '1);
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
module tb_sd_cmd_sequencer;
  localparam int SYNC = 2;
  localparam int MAXR = 3;
`ifdef SD_CMD_AUTO_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic         new_cmd = 0, crc_chk_en = 0, idx_chk_en = 0, data_read = 0, data_write = 0;
  logic [5:0]   cmd_index = 0;
  logic [31:0]  arg = 0;
  logic [1:0]   rsp_type = 0, word_sel = 0;
  logic [15:0]  timeout = 0;
  logic         int_clr = 0, req_in = 0, ack_in = 0, card_detect_n = 1;
  logic [127:0] cmd_in = 0;
  logic [7:0]   serial_status = 0;
  logic         busy, done_int, card_present, go_idle_o, req_out, ack_out;
  logic [127:0] resp;
  logic [4:0]   err_int;
  logic [2:0]   retry_cnt;
  logic [39:0]  cmd_out;
  logic [15:0]  settings;
  logic [1:0]   state_dbg;
  logic [7:0]   status_dbg;

  sd_cmd_sequencer dut (
    .clk(clk), .rst(rst), .new_cmd(new_cmd), .cmd_index(cmd_index), .arg(arg),
    .rsp_type(rsp_type), .crc_chk_en(crc_chk_en), .idx_chk_en(idx_chk_en),
    .data_read(data_read), .data_write(data_write), .word_sel(word_sel),
    .timeout(timeout), .int_clr(int_clr), .busy(busy), .resp(resp),
    .done_int(done_int), .err_int(err_int), .retry_cnt(retry_cnt),
    .card_present(card_present), .go_idle_o(go_idle_o), .cmd_out(cmd_out),
    .settings(settings), .req_out(req_out), .ack_out(ack_out), .req_in(req_in),
    .ack_in(ack_in), .cmd_in(cmd_in), .serial_status(serial_status),
    .card_detect_n(card_detect_n), .state_dbg(state_dbg), .status_dbg(status_dbg)
  );

  // scoreboard
  int total = 0;
  int bad = 0;
  int go_cnt = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_resp = '0;

  always @(posedge clk) begin
    #1;
    if (go_idle_o) go_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return req_out;
      1:       return ack_out;
      default: return busy;
    endcase
  endfunction

  task automatic wait_for(input int w, input logic v, input string tag);
    for (int i = 0; i < 300 && sig(w) !== v; i++) @(negedge clk);
    chk({tag, "_wait"}, 128'(sig(w)), 128'(v));
  endtask

  // driver tasks (host side and serial-engine side)
  task automatic issue(input logic [5:0] idx, input logic [31:0] a, input logic [1:0] rt,
                       input logic crc, input logic ien, input logic [1:0] ws,
                       input logic rd, input logic wr, input logic [15:0] to);
    cmd_index = idx; arg = a; rsp_type = rt; crc_chk_en = crc; idx_chk_en = ien;
    word_sel = ws; data_read = rd; data_write = wr; timeout = to;
    new_cmd = 1'b1;
    @(negedge clk);
    new_cmd = 1'b0;
  endtask

  task automatic engine_cmd(input string tag);
    wait_for(0, 1'b1, tag);
    ack_in = 1'b1;
    wait_for(0, 1'b0, tag);
    ack_in = 1'b0;
  endtask

  task automatic engine_rsp(input logic [7:0] st, input logic [127:0] d, input string tag);
    serial_status = st;
    cmd_in = d;
    req_in = 1'b1;
    wait_for(1, 1'b1, tag);
    req_in = 1'b0;
    wait_for(1, 1'b0, tag);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 128'(busy), 0);
    chk({tag, "_state"}, 128'(state_dbg), 0);
    chk({tag, "_resp"}, resp, 0);
    chk({tag, "_done"}, 128'(done_int), 0);
    chk({tag, "_err"}, 128'(err_int), 0);
    chk({tag, "_retry"}, 128'(retry_cnt), 0);
    chk({tag, "_cmd_out"}, 128'(cmd_out), 0);
    chk({tag, "_settings"}, 128'(settings), 0);
    chk({tag, "_req_ack_go"}, 128'({req_out, ack_out, go_idle_o, card_present}), 0);
  endtask

  // reference model: outcome of a command from the response rules
  function automatic void model(input logic crc, input logic ien, input logic match,
                                input logic [3:0] ok, output int attempts,
                                output logic [4:0] err);
    int a = 0;
    logic crc_bad, idx_bad;
    err = '0;
    forever begin
      crc_bad = crc && !ok[a];
      idx_bad = ien && !match;
      if (crc_bad && !idx_bad && RETRY && a < MAXR) begin
        a++;
      end else begin
        err[1] = crc_bad;
        err[3] = idx_bad;
        err[2] = RETRY && crc_bad && !idx_bad;
        err[4] = |err[3:0];
        attempts = a + 1;
        return;
      end
    end
  endfunction

  function automatic logic [15:0] exp_settings(input logic [1:0] ws, input logic rd,
                                               input logic wr, input logic crc,
                                               input logic [1:0] rt);
    logic [6:0] len;
    len = (rt == 2'b00) ? 7'd0 : (rt == 2'b01) ? 7'd127 : 7'd40;
    return {1'b0, ws, rd, wr, 3'b111, crc, len};
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [127:0] d, pat;
    logic [5:0]   idx, ridx;
    logic [31:0]  a;
    logic [1:0]   rt, ws;
    logic         crc, ien, match, rd, wr;
    logic [3:0]   ok;
    logic [4:0]   e;
    int           n, go0;

    // reset state
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // short response
    issue(6'd17, 32'h0000_0200, 2'b10, 0, 0, 2'b00, 0, 0, 16'd1000);
    wait_for(0, 1'b1, "short_req");
    chk("short_cmd_out", 128'(cmd_out), 128'(40'h51_0000_0200));
    chk("short_len", 128'(settings[6:0]), 128'(7'd40));
    engine_cmd("short_cmd");
    engine_rsp(8'h60, {90'd0, 6'd17, 32'h0000_0900}, "short_rsp");
    exp_resp = 128'h900;
    chk("short_resp", resp, exp_resp);
    chk("short_done", 128'(done_int), 1);
    chk("short_err", 128'(err_int), 0);
    chk("short_busy", 128'(busy), 0);

    // long response
    for (int i = 0; i < 16; i++) pat[i*8 +: 8] = 8'hA5;
    issue(6'd2, 32'h0, 2'b01, 0, 0, 2'b00, 0, 0, 16'd1000);
    wait_for(0, 1'b1, "long_req");
    chk("long_len", 128'(settings[6:0]), 128'(7'd127));
    engine_cmd("long_cmd");
    engine_rsp(8'h60, pat, "long_rsp");
    exp_resp = pat;
    chk("long_resp", resp, exp_resp);
    chk("long_done", 128'(done_int), 1);

    // timeout: engine takes the command but never answers
    go0 = go_cnt;
    issue(6'd17, 32'h0, 2'b10, 0, 0, 2'b00, 0, 0, 16'd20);
    n = RETRY ? MAXR + 1 : 1;
    for (int i = 0; i < n; i++) begin
      engine_cmd("to_cmd");
      if (i == 0) begin
        repeat (10) @(negedge clk);
        chk("to_early_go", 128'(go_cnt - go0), 0);
        chk("to_early_busy", 128'(busy), 1);
      end
    end
    wait_for(2, 1'b0, "to_idle");
    repeat (2) @(negedge clk);
    chk("to_go_pulses", 128'(go_cnt - go0), 128'(n));
    chk("to_err", 128'(err_int), RETRY ? 128'(5'b10101) : 128'(5'b10001));
    chk("to_retry", 128'(retry_cnt), RETRY ? 128'(MAXR) : 0);
    chk("to_done", 128'(done_int), 0);

    // CRC error (re-issued once in the retry build)
    issue(6'd17, 32'h1, 2'b10, 1, 0, 2'b00, 0, 0, 16'd1000);
    engine_cmd("crc_cmd0");
    engine_rsp(8'h40, {90'd0, 6'd17, 32'h0000_0111}, "crc_rsp0");
    if (RETRY) begin
      engine_cmd("crc_cmd1");
      engine_rsp(8'h60, {90'd0, 6'd17, 32'h0000_0222}, "crc_rsp1");
      exp_resp = 128'h222;
    end else begin
      exp_resp = 128'h111;
    end
    chk("crc_retry", 128'(retry_cnt), RETRY ? 1 : 0);
    chk("crc_err", 128'(err_int), RETRY ? 0 : 128'(5'b10010));
    chk("crc_done", 128'(done_int), 1);
    chk("crc_resp", resp, exp_resp);

    // index mismatch is never re-issued
    issue(6'd17, 32'h2, 2'b10, 0, 1, 2'b00, 0, 0, 16'd1000);
    engine_cmd("idx_cmd");
    engine_rsp(8'h60, {90'd0, 6'd3, 32'h0000_0333}, "idx_rsp");
    exp_resp = 128'h333;
    chk("idx_err", 128'(err_int), 128'(5'b11000));
    chk("idx_retry", 128'(retry_cnt), 0);
    chk("idx_busy", 128'(busy), 0);
    int_clr = 1'b1;
    @(negedge clk);
    int_clr = 1'b0;
    chk("clr_flags", 128'({done_int, err_int}), 0);

    // card detect debounce
    card_detect_n = 1'b0;
    repeat (15) @(negedge clk);
    chk("card_before", 128'(card_present), 0);
    @(negedge clk);
    chk("card_after16", 128'(card_present), 1);
    card_detect_n = 1'b1;
    @(negedge clk);
    chk("card_removed", 128'(card_present), 0);

    // reset in the middle of EXECUTE
    go0 = go_cnt;
    issue(6'd5, 32'h3, 2'b10, 0, 0, 2'b01, 1, 0, 16'd1000);
    engine_cmd("rst_cmd");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    exp_resp = '0;
    @(negedge clk);
    chk("midrst_go", 128'(go_cnt - go0), 0);

    // int_clr coincident with a flag set (CRC + index error, never re-issued)
    issue(6'd17, 32'h4, 2'b10, 1, 1, 2'b00, 0, 0, 16'd1000);
    engine_cmd("clr_cmd");
    serial_status = 8'h40;
    cmd_in = {90'd0, 6'd3, 32'h0000_0444};
    req_in = 1'b1;
    repeat (SYNC) @(negedge clk);
    int_clr = 1'b1;
    @(negedge clk);
    int_clr = 1'b0;
    exp_resp = 128'h444;
    chk("clr_coincident_err", 128'(err_int), 0);
    chk("clr_coincident_done", 128'(done_int), 0);
    chk("clr_coincident_busy", 128'(busy), 0);
    wait_for(1, 1'b1, "clr_ack");
    req_in = 1'b0;
    wait_for(1, 1'b0, "clr_ack");

    // randomized commands against the model
    for (int t = 0; t < 12; t++) begin
      idx = 6'($urandom_range(0, 63)); a = $urandom; rt = 2'($urandom_range(0, 3));
      crc = 1'($urandom_range(0, 1)); ien = 1'($urandom_range(0, 1));
      match = ($urandom_range(0, 2) != 0); ok = 4'($urandom_range(0, 15));
      ws = 2'($urandom_range(0, 3)); rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
      ridx = match ? idx : idx ^ 6'($urandom_range(1, 63));
      d = {$urandom, $urandom, $urandom, $urandom};
      d[37:32] = ridx;
      model(crc, ien, match, ok, n, e);
      if (rt == 2'b01) exp_resp = d;
      else if (rt != 2'b00) exp_resp = {96'd0, d[31:0]};
      exp_q.push_back(exp_resp);
      issue(idx, a, rt, crc, ien, ws, rd, wr, 16'd1000);
      wait_for(0, 1'b1, "rnd_req");
      chk("rnd_cmd_out", 128'(cmd_out), 128'({2'b01, idx, a}));
      chk("rnd_settings", 128'(settings), 128'(exp_settings(ws, rd, wr, crc, rt)));
      for (int k = 0; k < n; k++) begin
        engine_cmd("rnd_cmd");
        engine_rsp(ok[k] ? 8'h60 : 8'h40, d, "rnd_rsp");
      end
      chk("rnd_busy", 128'(busy), 0);
      chk("rnd_err", 128'(err_int), 128'(e));
      chk("rnd_done", 128'(done_int), 1);
      chk("rnd_retry", 128'(retry_cnt), 128'(n - 1));
      chk("rnd_resp", resp, exp_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
